// File: rtl/fft_bitrev_feeder.sv
// fft_bitrev_feeder: ping-pong frame buffer emitting bit-reversed butterfly input pairs.
module fft_bitrev_feeder #(
  parameter int N     = 16,
  parameter int Q     = 1,
  parameter int LOG2P = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r,
  input  logic [N-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [N-1:0] out0_r,
  output logic [N-1:0] out0_i,
  output logic [N-1:0] out1_r,
  output logic [N-1:0] out1_i,
  output logic [N-1:0] twiddle_r,
  output logic [N-1:0] twiddle_i
);
  localparam int P  = 1 << LOG2P;
  localparam int RW = LOG2P > 1 ? LOG2P - 1 : 1;
  typedef enum logic {IDLE, READ} state_t;
  logic [N-1:0]     mem_r_q [2][P];
  logic [N-1:0]     mem_i_q [2][P];
  logic             wbank_q, rbank_q, out_valid_q, out_last_q;
  logic [LOG2P-1:0] wcnt_q, a0, a1;
  logic [1:0]       full_q, full_d;
  logic [RW-1:0]    rcnt_q;
  logic [N-1:0]     out0_r_q, out0_i_q, out1_r_q, out1_i_q;
  state_t           state_q;
  logic             wr, wdone, last, ld, rdone;
  function automatic logic [LOG2P-1:0] rev(input logic [LOG2P-1:0] a);
    for (int k = 0; k < LOG2P; k++) rev[k] = a[LOG2P-1-k];
  endfunction
  assign in_ready  = !full_q[wbank_q];
  assign wr        = in_valid && in_ready;
  assign wdone     = wr && wcnt_q == LOG2P'(P - 1);
  assign last      = rcnt_q == RW'(P / 2 - 1);
  assign ld        = state_q == READ && (!out_valid_q || out_ready);
  assign rdone     = ld && last;
  assign a0        = rev(LOG2P'({rcnt_q, 1'b0}));
  assign a1        = rev(LOG2P'({rcnt_q, 1'b1}));
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out0_r    = out0_r_q;
  assign out0_i    = out0_i_q;
  assign out1_r    = out1_r_q;
  assign out1_i    = out1_i_q;
  assign twiddle_r = N'(1) << Q;
  assign twiddle_i = '0;
  // set and clear of full always hit different banks, so both apply
  always_comb begin
    full_d = full_q;
    if (wdone) full_d[wbank_q] = 1'b1;
    if (rdone) full_d[rbank_q] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_r_q[wbank_q][wcnt_q] <= in_r;
      mem_i_q[wbank_q][wcnt_q] <= in_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      full_q      <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out0_r_q    <= '0;
      out0_i_q    <= '0;
      out1_r_q    <= '0;
      out1_i_q    <= '0;
    end else begin
      full_q <= full_d;
      if (wr) wcnt_q <= wcnt_q + 1'b1;
      if (wdone) wbank_q <= ~wbank_q;
      if (state_q == IDLE && full_q[rbank_q]) state_q <= READ;
      if (ld) begin
        out0_r_q    <= mem_r_q[rbank_q][a0];
        out0_i_q    <= mem_i_q[rbank_q][a0];
        out1_r_q    <= mem_r_q[rbank_q][a1];
        out1_i_q    <= mem_i_q[rbank_q][a1];
        out_valid_q <= 1'b1;
        out_last_q  <= last;
        rcnt_q      <= last ? '0 : rcnt_q + 1'b1;
        if (last) begin
          rbank_q <= ~rbank_q;
          state_q <= full_q[~rbank_q] ? READ : IDLE;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fft_bitrev_feeder.md
# fft_bitrev_feeder

Input stage of the radix-2 FFT datapath, directly upstream of the `butterfly2` stage. Accepts a serial stream of complex fixed-point samples and buffers one frame of `2**LOG2P` points in a ping-pong memory. Each full frame is emitted as butterfly input pairs in bit-reversed order. Each pair comes with the stage-0 twiddle factor W^0 = 1 + j0, so the output drives the butterfly's `in0_*`, `in1_*` and `twiddle_*` inputs directly.

## Interface
Parameters:
- `N`, 16, data width (two's complement, fixed point; same meaning as the butterfly's `N`)
- `Q`, 1, fractional bits (same meaning as the butterfly's `Q`); used only for the twiddle constant
- `LOG2P`, 3, log2 of frame length; `P = 2**LOG2P` points, `P/2` pairs per frame; legal range 1..10

Ports:
- Reset is asynchronous and active-high.
- `clk`, input, 1: the single clock; all state updates on the rising edge
- `rst`, input, 1: asynchronous, active-high reset
- `in_valid`, input, 1: input sample present
- `in_ready`, output, 1: block can accept a sample; a sample transfers when `in_valid && in_ready`
- `in_r`, `in_i`, input, N: real and imaginary parts of the input sample
- `out_valid`, output, 1: output pair present
- `out_ready`, input, 1: downstream accepts the pair; the pair transfers when `out_valid && out_ready`
- `out_last`, output, 1: marks the final pair of a frame; qualified by `out_valid`
- `out0_r`, `out0_i`, `out1_r`, `out1_i`, output, N: the butterfly operands
- `twiddle_r`, `twiddle_i`, output, N: constant twiddle, `twiddle_r = 1 << Q`, `twiddle_i = 0`

## Operation
- Storage: two banks, each holding `P` complex entries, built from register arrays with two combinational read ports. Memory contents are not reset.
- State: `wbank`, `wcnt[LOG2P-1:0]`, `full[1:0]`, `rbank`, `rcnt[LOG2P-2:0]` (1 bit minimum when `LOG2P=1`).
- Write side:
  - `in_ready = !full[wbank]`.
  - On each input transfer, store the sample at `bank[wbank][wcnt]` in natural order and increment `wcnt`.
  - On the transfer where `wcnt == P-1`: set `full[wbank]`, toggle `wbank`, and wrap `wcnt` to 0.
- Read side: a two-state FSM.
  - IDLE → READ when `full[rbank]`.
  - In READ, a pair is loaded into the output registers whenever `!out_valid || out_ready`. The load is:
    - `out0 = bank[rbank][rev(2*rcnt)]` and `out1 = bank[rbank][rev(2*rcnt+1)]`, where `rev()` reverses the bits of the LOG2P-bit index.
    - `out_valid <= 1`, and `out_last <= (rcnt == P/2-1)`.
    - `rcnt` increments.
  - After the last pair of a bank is loaded: clear `full[rbank]`, toggle `rbank`, wrap `rcnt` to 0.
    - If the other bank is already full, stay in READ and continue with no bubble.
    - Otherwise go to IDLE.
  - If no load happens and `out_ready` is high, `out_valid <= 0`.
  - While `out_valid && !out_ready`, all outputs hold and `rcnt` holds.
- Simultaneous events: a set of `full` and a clear of `full` in the same cycle always target different banks. Both take effect.
- Twiddle outputs are constant, independent of valid, and not registered.

## Timing
- Reset values:
  - `out_valid=0`, `out_last=0`, all `out0_*`/`out1_*` = 0.
  - `wbank=rbank=0`, `wcnt=rcnt=0`, `full=2'b00`, FSM in IDLE.
  - Hence `in_ready=1` after reset.
- Latency: the last sample of a frame is accepted at edge t.
  - The FSM enters READ at edge t+1.
  - The first pair is registered at edge t+2, so `out_valid` goes high after edge t+2.
  - With `out_ready` held high, the pairs occupy consecutive cycles; `out_last` is on the P/2-th.
- Throughput: one sample per cycle in, one pair per cycle out. With `out_ready` held high, continuous streaming never deasserts `in_ready`.
- Backpressure: if both banks are full, `in_ready` is low until the read side finishes its bank. `in_ready` rises the cycle after the last pair of that bank is loaded.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values immediately (asynchronous). The first transfer after reset is sample 0 of a new frame.

## Test plan
- Reset, then frame `LOG2P=3`, `in_r = 0..7`, `in_i = 0`, `out_ready = 1`.
  - Required pairs (`out0_r`, `out1_r`): (0,4), (2,6), (1,5), (3,7).
  - `out_last` is high on (3,7) only.
  - The first `out_valid` is 2 cycles after the 8th input transfer.
  - `twiddle_r = 2`, `twiddle_i = 0`.
- Three back-to-back frames of 24 consecutive samples, values 100..123.
  - `in_ready` stays 1 throughout.
  - Frame 2 pairs are (108,112), (110,114), (109,113), (111,115).
  - Frame 3 pairs are (116,120), (118,122), (117,121), (119,123).
- `out_ready = 0` throughout; stream 20 samples.
  - `in_ready` falls after the 16th transfer.
  - `out_valid` holds pair (0,4) with values stable.
  - Raise `out_ready`: 8 pairs drain, then `in_ready` returns to 1.
- `out_ready` toggled 1,0,1,0 during a frame.
  - Every pair appears exactly once, in bit-reversed order.
  - No pair is duplicated or skipped.
  - Outputs are stable while stalled.
- Assert `rst` asynchronously after the 5th sample.
  - Outputs and flags are cleared without waiting for a clock edge.
  - The next 8 samples, 50..57, yield (50,54), (52,56), (51,55), (53,57).
- Negative and imaginary data, `in_i = -(k+1)`.
  - `out1_i` of the first pair is -5.
  - The full-scale value `-2**(N-1)` passes through unchanged.
